// File: rtl/alu_core.sv
// alu_core: 6502-style ALU stage; computes the strobed operation and captures it in ADD with ACR/AVR/HC.
// Ports: clk, reset (sync, active-high), a_in/b_in operands, I_ADDC carry/shift-in,
//   SUMS/ANDS/EORS/ORS/SRS op strobes (priority SUMS > SRS > ANDS > EORS > ORS),
//   DAA/DSA decimal qualifiers for SUMS, add_out hold register, ACR/AVR/HC registered flags.
// Optional macro: ALU_DECIMAL_EN enables same-cycle BCD correction of SUMS (WIDTH=8 only).
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             I_ADDC,
    input  logic             SUMS,
    input  logic             ANDS,
    input  logic             EORS,
    input  logic             ORS,
    input  logic             SRS,
    input  logic             DAA,
    input  logic             DSA,
    output logic [WIDTH-1:0] add_out,
    output logic             ACR,
    output logic             AVR,
    output logic             HC
);
    logic [WIDTH:0]   s;
    logic [4:0]       n;
    logic             av;
    logic [WIDTH-1:0] sum_r;
    logic             sum_c;
    logic [WIDTH-1:0] nr;
    logic             nc;
    logic             en;
`ifdef ALU_DECIMAL_EN
    // lo is 9 bits so a +6 that overflows the byte still counts as "> 8'h99"
    logic [8:0]       lo;
    logic             hi_adj;
    logic [7:0]       daa_r;
    logic [7:0]       dsa_r;
`else
    logic             unused_dec;
    assign unused_dec = DAA ^ DSA;
`endif
    always_comb begin
        s     = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, I_ADDC};
        n     = {1'b0, a_in[3:0]} + {1'b0, b_in[3:0]} + {4'b0, I_ADDC};
        av    = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s[WIDTH-1] != a_in[WIDTH-1]);
`ifdef ALU_DECIMAL_EN
        lo     = {1'b0, s[7:0]} + ((s[3:0] > 4'd9 || n[4]) ? 9'd6 : 9'd0);
        hi_adj = (lo > 9'h099) || s[8];
        daa_r  = lo[7:0] + (hi_adj ? 8'h60 : 8'h00);
        dsa_r  = s[7:0] - (n[4] ? 8'h00 : 8'h06) - (s[8] ? 8'h00 : 8'h60);
        // DAA and DSA together fall back to a plain binary add
        sum_r  = (DAA && !DSA) ? daa_r : (DSA && !DAA) ? dsa_r : s[WIDTH-1:0];
        sum_c  = (DAA && !DSA) ? hi_adj : s[WIDTH];
`else
        sum_r  = s[WIDTH-1:0];
        sum_c  = s[WIDTH];
`endif
        nr = SUMS ? sum_r : SRS ? {I_ADDC, a_in[WIDTH-1:1]} : ANDS ? (a_in & b_in) :
             EORS ? (a_in ^ b_in) : (a_in | b_in);
        nc = SUMS ? sum_c : SRS ? a_in[0] : 1'b0;
        en = SUMS | SRS | ANDS | EORS | ORS;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            add_out <= '0;
            ACR     <= 1'b0;
            AVR     <= 1'b0;
            HC      <= 1'b0;
        end else if (en) begin
            add_out <= nr;
            ACR     <= nc;
            AVR     <= SUMS & av;
            HC      <= SUMS & n[4];
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: self-checking bench for alu_core (directed table, hand sequences, random vs. reference model).
module tb_alu_core;
    typedef struct packed {
        logic [6:0]  st;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [10:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_in, b_in;
    logic       I_ADDC, SUMS, ANDS, EORS, ORS, SRS, DAA, DSA;
    logic [7:0] add_out;
    logic       ACR, AVR, HC;
    int         checks = 0;
    int         failures = 0;
    vec_t       tbl[$];
    logic [10:0] m_state;

    always #5 clk = ~clk;

    alu_core dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .I_ADDC(I_ADDC),
        .SUMS(SUMS), .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS),
        .DAA(DAA), .DSA(DSA), .add_out(add_out), .ACR(ACR), .AVR(AVR), .HC(HC)
    );

    // st = {SUMS, SRS, ANDS, EORS, ORS, DAA, DSA}
    localparam logic [6:0] S_SUM = 7'b1000000, S_SRS = 7'b0100000, S_AND = 7'b0010000,
                           S_EOR = 7'b0001000, S_OR = 7'b0000100, S_DAA = 7'b0000010,
                           S_DSA = 7'b0000001;

    task automatic drive(input logic [6:0] st, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic rst);
        {SUMS, SRS, ANDS, EORS, ORS, DAA, DSA} = st;
        a_in = a; b_in = b; I_ADDC = cin; reset = rst;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        checks++;
        if ({add_out, ACR, AVR, HC} !== exp) begin
            failures++;
            $display("FAIL %s got out=%h c=%b v=%b h=%b exp out=%h c=%b v=%b h=%b",
                     name, add_out, ACR, AVR, HC, exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Reference: plain integer arithmetic on the operation rules, winner already known to exist.
    function automatic logic [10:0] model(input logic [6:0] st, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        int sum, sa, sb, r;
        bit c, v, h;
        sum = int'(a) + int'(b) + int'(cin);
        sa  = a >= 128 ? int'(a) - 256 : int'(a);
        sb  = b >= 128 ? int'(b) - 256 : int'(b);
        v   = (sa + sb + int'(cin)) > 127 || (sa + sb + int'(cin)) < -128;
        h   = (int'(a % 16) + int'(b % 16) + int'(cin)) > 15;
        if (st[6]) begin
            r = sum % 256;
            c = sum > 255;
`ifdef ALU_DECIMAL_EN
            if (st[1] && !st[0]) begin
                if (r % 16 > 9 || h) r += 6;
                if (r > 'h99 || sum > 255) begin r += 'h60; c = 1; end
                r = r % 256;
            end else if (st[0] && !st[1]) begin
                r = r - (h ? 0 : 6) - (sum > 255 ? 0 : 'h60);
                r = (r + 512) % 256;
            end
`endif
            return {8'(r), c, v, h};
        end
        if (st[5]) return {cin, a[7:1], a[0], 2'b00};
        if (st[4]) return {a & b, 3'b000};
        if (st[3]) return {a ^ b, 3'b000};
        return {a | b, 3'b000};
    endfunction

    initial begin
        drive(7'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        drive(S_SUM, 8'h55, 8'h22, 1'b1, 1'b1);
        tick();
        check("reset_with_sums", 11'h000);

        tbl.push_back({S_SUM, 8'h7F, 8'h01, 1'b0, {8'h80, 3'b011}});
        tbl.push_back({S_SUM, 8'hFF, 8'h01, 1'b0, {8'h00, 3'b101}});
        tbl.push_back({S_SRS, 8'h81, 8'h00, 1'b1, {8'hC0, 3'b100}});
        tbl.push_back({S_SRS | S_AND, 8'h81, 8'h0F, 1'b1, {8'hC0, 3'b100}});
        tbl.push_back({S_AND, 8'hF0, 8'h3C, 1'b0, {8'h30, 3'b000}});
        tbl.push_back({S_EOR, 8'hF0, 8'h3C, 1'b1, {8'hCC, 3'b000}});
        tbl.push_back({S_OR, 8'hF0, 8'h3C, 1'b0, {8'hFC, 3'b000}});
        tbl.push_back({S_SUM | S_SRS, 8'h10, 8'h20, 1'b1, {8'h31, 3'b000}});
        tbl.push_back({S_AND | S_EOR | S_OR, 8'hF0, 8'h3C, 1'b0, {8'h30, 3'b000}});
        tbl.push_back({S_EOR | S_OR, 8'hF0, 8'h3C, 1'b0, {8'hCC, 3'b000}});
        tbl.push_back({S_SUM, 8'h80, 8'h80, 1'b0, {8'h00, 3'b110}});
        tbl.push_back({S_SUM | S_DAA | S_DSA, 8'h45, 8'h38, 1'b0, {8'h7D, 3'b000}});
`ifdef ALU_DECIMAL_EN
        tbl.push_back({S_SUM | S_DAA, 8'h45, 8'h38, 1'b0, {8'h83, 3'b000}});
        tbl.push_back({S_SUM | S_DAA, 8'h99, 8'h01, 1'b0, {8'h00, 3'b100}});
        tbl.push_back({S_SUM | S_DSA, 8'h45, 8'hC7, 1'b1, {8'h07, 3'b100}});
`else
        tbl.push_back({S_SUM | S_DAA, 8'h45, 8'h38, 1'b0, {8'h7D, 3'b000}});
        tbl.push_back({S_SUM | S_DAA, 8'h99, 8'h01, 1'b0, {8'h9A, 3'b000}});
        tbl.push_back({S_SUM | S_DSA, 8'h45, 8'hC7, 1'b1, {8'h0D, 3'b100}});
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        drive(S_SUM, 8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        drive(7'd0, 8'h12, 8'h34, 1'b1, 1'b0);
        tick();
        check("hold_1", {8'h80, 3'b011});
        tick();
        check("hold_2", {8'h80, 3'b011});
        drive(S_DAA | S_DSA, 8'h99, 8'h99, 1'b1, 1'b0);
        tick();
        check("daa_without_sums", {8'h80, 3'b011});
        drive(S_SUM | S_SRS | S_OR, 8'hFF, 8'hFF, 1'b1, 1'b1);
        tick();
        check("reset_mid_op", 11'h000);

        m_state = 11'h000;
        for (int k = 0; k < 400; k++) begin
            logic [6:0] st;
            logic [7:0] a, b;
            logic cin, rst;
            st  = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                   $urandom_range(0, 2) == 0};
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            rst = $urandom_range(0, 19) == 0;
            drive(st, a, b, cin, rst);
            m_state = rst ? 11'h000 : (|st[6:2]) ? model(st, a, b, cin) : m_state;
            tick();
            check($sformatf("rand%0d", k), m_state);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
